// File: rtl/aes_sbox_pkg.sv
// Composite-field GF((2^4)^2) constants and helpers for the AES S-box.
// DELTA/DELTA_INV are derived at elaboration from a root of the AES polynomial.
package aes_sbox_pkg;

  typedef logic [7:0][7:0] mat8_t;

  localparam logic [3:0] LAMBDA       = 4'hC;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  // GF(2^4) multiply modulo x^4+x+1
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = ({7{b[0]}} & {3'b000, a}) ^ ({7{b[1]}} & {2'b00, a, 1'b0}) ^
        ({7{b[2]}} & {1'b0, a, 2'b00}) ^ ({7{b[3]}} & {a, 3'b000});
    return {p[3] ^ p[6], p[2] ^ p[5] ^ p[6], p[1] ^ p[4] ^ p[5], p[0] ^ p[4]};
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

  // a^14 = a^-1, and maps 0 to 0
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf16_sq(a);
    a4 = gf16_sq(a2);
    a8 = gf16_sq(a4);
    return gf16_mul(gf16_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] gf256c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(LAMBDA, hh) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] mat_vec(input mat8_t m, input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(m[i] & x);
    end
    return y;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] a);
    return a ^ {a[3:0], a[7:4]} ^ {a[4:0], a[7:5]} ^ {a[5:0], a[7:6]} ^
           {a[6:0], a[7]} ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] y);
    return {y[1:0], y[7:2]} ^ {y[4:0], y[7:5]} ^ {y[6:0], y[7]} ^ INV_AFFINE_C;
  endfunction

  // Column k of delta is g^k, where g is a composite-field root of x^8+x^4+x^3+x+1
  function automatic mat8_t gen_delta();
    logic [8:0][7:0] pw;
    mat8_t           m;
    logic            found;
    m     = '0;
    pw    = '0;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      if (!found) begin
        pw[0] = 8'h01;
        for (int k = 1; k < 9; k++) begin
          pw[k] = gf256c_mul(pw[k-1], c[7:0]);
        end
        if ((pw[8] ^ pw[4] ^ pw[3] ^ pw[1] ^ pw[0]) == 8'h00) begin
          found = 1'b1;
          for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
              m[i][k] = pw[k][i];
            end
          end
        end
      end
    end
    return m;
  endfunction

  function automatic mat8_t gen_delta_inv(input mat8_t m);
    mat8_t      inv;
    logic [7:0] v;
    inv = '0;
    for (int b = 0; b < 256; b++) begin
      v = mat_vec(m, b[7:0]);
      for (int j = 0; j < 8; j++) begin
        if (v == (8'h01 << j)) begin
          for (int i = 0; i < 8; i++) begin
            inv[i][j] = b[i];
          end
        end
      end
    end
    return inv;
  endfunction

  localparam mat8_t DELTA     = gen_delta();
  localparam mat8_t DELTA_INV = gen_delta_inv(DELTA);

endpackage

// File: rtl/aes_gf256_inv_composite.sv
// Combinational GF((2^4)^2) inverse, split at d^-1 so the caller may register the
// midpoint {ah, ah^al, d^-1}; o_y is computed from i_mid.
module aes_gf256_inv_composite
  import aes_sbox_pkg::*;
(
  input  logic [7:0]  i_x,
  output logic [11:0] o_mid,
  input  logic [11:0] i_mid,
  output logic [7:0]  o_y
);

  logic [3:0] w_ah;
  logic [3:0] w_al;
  logic [3:0] w_d;

  assign w_ah = i_x[7:4];
  assign w_al = i_x[3:0];

  // Norm of ah*y+al; zero input gives d=0 and hence a zero inverse
  assign w_d   = gf16_mul(LAMBDA, gf16_sq(w_ah)) ^ gf16_mul(w_ah, w_al) ^ gf16_sq(w_al);
  assign o_mid = {w_ah, w_ah ^ w_al, gf16_inv(w_d)};

  assign o_y = {gf16_mul(i_mid[11:8], i_mid[3:0]), gf16_mul(i_mid[7:4], i_mid[3:0])};

endmodule

// File: rtl/aes_sbox_composite.sv
// Shared forward/inverse AES S-box via one composite-field inverter.
// Define SBOX_PIPE_EN to register the inverter midpoint (2-clk latency).
module aes_sbox_composite
  import aes_sbox_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enc_dec,
  input  logic       i_valid_in,
  input  logic [7:0] i_data_in,
  output logic       o_valid_out,
  output logic [7:0] o_data_out
);

  logic [7:0]  w_pre;
  logic [7:0]  w_iso;
  logic [11:0] w_mid_d;
  logic [11:0] w_mid_q;
  logic [7:0]  w_inv;
  logic [7:0]  w_post;
  logic [7:0]  w_out;
  logic        w_enc_q;
  logic        w_vld_q;
  logic [7:0]  r_data;
  logic        r_valid;

  // Decrypt undoes the affine step before entering the composite field
  always_comb begin
    w_pre = i_data_in;
    if (i_enc_dec) begin
      w_pre = i_data_in;
    end else begin
      w_pre = affine_inv(i_data_in);
    end
  end

  assign w_iso = mat_vec(DELTA, w_pre);

  aes_gf256_inv_composite u_inv (
    .i_x   (w_iso),
    .o_mid (w_mid_d),
    .i_mid (w_mid_q),
    .o_y   (w_inv)
  );

  assign w_post = mat_vec(DELTA_INV, w_inv);

  // Encrypt applies the affine step after leaving the composite field
  always_comb begin
    w_out = w_post;
    if (w_enc_q) begin
      w_out = affine_fwd(w_post);
    end else begin
      w_out = w_post;
    end
  end

`ifdef SBOX_PIPE_EN
  logic [11:0] r_mid;
  logic        r_enc_p;
  logic        r_vld_p;

  // Midpoint stage: the direction bit travels with its own byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mid   <= 12'h000;
      r_enc_p <= 1'b0;
      r_vld_p <= 1'b0;
    end else begin
      r_vld_p <= i_valid_in;
      if (i_valid_in) begin
        r_mid   <= w_mid_d;
        r_enc_p <= i_enc_dec;
      end
    end
  end

  assign w_mid_q = r_mid;
  assign w_enc_q = r_enc_p;
  assign w_vld_q = r_vld_p;
`else
  assign w_mid_q = w_mid_d;
  assign w_enc_q = i_enc_dec;
  assign w_vld_q = i_valid_in;
`endif

  // Output register holds its value across idle cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_vld_q;
      if (w_vld_q) begin
        r_data <= w_out;
      end
    end
  end

  assign o_valid_out = r_valid;
  assign o_data_out  = r_data;

endmodule

// File: tb/tb_aes_sbox_composite.sv
// Scoreboard bench for aes_sbox_composite; reference S-box built from GF(2^8)
// arithmetic and the affine rule. Latency follows SBOX_PIPE_EN.
module tb_aes_sbox_composite;

`ifdef SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc;
  logic       vld;
  logic [7:0] din;
  logic       vout;
  logic [7:0] dout;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];
  logic [7:0] last_exp = 8'h00;
  logic       mon_en   = 1'b0;
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  aes_sbox_composite dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enc_dec   (enc),
    .i_valid_in  (vld),
    .i_data_in   (din),
    .o_valid_out (vout),
    .o_data_out  (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) r = 8'(c);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] a);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic send(input logic e, input logic [7:0] d, input logic [7:0] x);
    rst = 1'b0;
    vld = 1'b1;
    enc = e;
    din = d;
    sb_q.push_back('{data: x, due: cyc + LAT});
    @(posedge clk);
    #1;
  endtask

  task automatic send_model(input logic e, input logic [7:0] d);
    send(e, d, e ? sbox[d] : inv_sbox[d]);
  endtask

  task automatic gap();
    rst = 1'b0;
    vld = 1'b0;
    enc = 1'($urandom);
    din = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    vld = 1'b1;
    enc = 1'b1;
    din = 8'h53;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      sb_q.delete();
      last_exp = 8'h00;
      mon_en   = 1'b1;
      chk("rst_valid", 32'(vout), 32'd0);
      chk("rst_data", 32'(dout), 32'h00);
    end
    rst = 1'b0;
    vld = 1'b0;
  endtask

  // Monitor: pop on valid, otherwise the output must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (vout === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("spurious_valid", 32'(vout), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("data", 32'(dout), 32'(mon_e.data));
          chk("latency", 32'(cyc), 32'(mon_e.due));
          last_exp = mon_e.data;
        end
      end else begin
        chk("valid_low", 32'(vout), 32'd0);
        chk("hold", 32'(dout), 32'(last_exp));
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          void'(sb_q.pop_front());
          chk("missing_output", 32'(vout), 32'd1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vld = 1'b1;
    enc = 1'b1;
    din = 8'h53;
    for (int x = 0; x < 256; x++) begin
      sbox[x] = aff(ginv(8'(x)));
    end
    for (int x = 0; x < 256; x++) begin
      inv_sbox[sbox[x]] = 8'(x);
    end

    reset_pulse(2);
    gap();

    send(1'b1, 8'h00, 8'h63);
    send(1'b1, 8'h53, 8'hED);
    send(1'b1, 8'hFF, 8'h16);
    send(1'b1, 8'hAA, 8'hAC);
    for (int x = 0; x < 32; x++) send_model(1'b1, 8'(x));
    send(1'b1, 8'h01, 8'h7C);
    send(1'b1, 8'h10, 8'hCA);
    send(1'b1, 8'h1F, 8'hC0);
    gap();

    send(1'b0, 8'h63, 8'h00);
    send(1'b0, 8'hED, 8'h53);
    send(1'b0, 8'h7C, 8'h01);
    send(1'b0, 8'h16, 8'hFF);
    send(1'b0, 8'hAC, 8'hAA);
    gap();

    for (int x = 0; x < 16; x++) send(1'b0, sbox[x], 8'(x));
    for (int i = 0; i < 32; i++) send_model(1'(i), 8'($urandom));
    gap();

    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 256; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) gap();
        end
        send_model(1'(m), 8'(x));
      end
    end

    // Mid-stream reset with results still coming out
    send_model(1'b1, 8'h3C);
    send_model(1'b0, 8'h9A);
    send_model(1'b1, 8'hC3);
    chk("midrst_pre_valid", 32'(vout), 32'd1);
    reset_pulse(1);
    gap();
    send_model(1'b1, 8'h42);
    send_model(1'b0, 8'h42);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) gap();
    chk("drain", 32'(sb_q.size()), 32'd0);
    gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
